dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the 16-bit pipelined CPU's MEM stage (EX/MEM pipe side).
//  - Services one load/store request at a time, inserting WAIT_STATES cycles of latency.
//  - Drives mem_stall back to the hazard logic, which freezes the pipe registers.
//  - Word-addressed 16-bit storage. Registered read data is presented to the MEM/WB capture.
// PARAMETERS
//  DEPTH        256  number of 16-bit words; power of two, >= 2
//  WAIT_STATES  1    stall cycles per access; legal range 1..15 (0 is illegal)
// PORTS
//  clk          in   1   system clock; all state changes on posedge
//  pc_reset_n   in   1   asynchronous, active-low reset
//  mem_read     in   1   load request; level, held by pipe while mem_stall=1
//  mem_write    in   1   store request; level, held by pipe while mem_stall=1
//  addr         in   16  word address; low log2(DEPTH) bits used
//  wdata        in   16  store data; sampled at commit edge
//  rdata        out  16  load data; registered
//  rdata_valid  out  1   one-cycle pulse when rdata updated by completing load
//  mem_stall    out  1   hold pipeline; combinational from state/request
//  parity_err   out  1   only with DMEM_PARITY_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-access):
//    - state=IDLE, cnt=0, rdata=0, rdata_valid=0, parity_err=0.
//    - Pending access aborted; array contents NOT cleared.
//  - req = mem_read | mem_write. Both high: treated as store; rdata unchanged, no rdata_valid.
//  - FSM IDLE/WAIT/DONE, cnt 4-bit:
//    - IDLE: req=1 -> WAIT, cnt=WAIT_STATES-1; mem_stall=1 this cycle (cycle T).
//    - WAIT: mem_stall=req.
//      - req=0 (flush) -> IDLE, no commit.
//      - cnt!=0 -> cnt-1.
//      - cnt==0 -> commit at this edge, -> DONE.
//    - DONE: mem_stall=0; request ignored (pipe advances this edge); -> IDLE unconditionally.
//  - Timing, request first seen in cycle T:
//    - mem_stall=1 during T..T+WAIT_STATES-1.
//    - Commit edge = end of T+WAIT_STATES-1. Store writes mem[addr]<=wdata. Load latches rdata<=mem[addr].
//    - rdata/rdata_valid visible in cycle T+WAIT_STATES (DONE); mem_stall=0 there.
//  - rdata holds its value until the next completed load. rdata_valid=1 only in DONE after a load.
//  - Back-to-back: next request seen in IDLE at T+WAIT_STATES+1; no request lost or merged.
//  - Address wrap: addr>=DEPTH aliases to addr mod DEPTH; no error.
//  - Store-then-load same address returns the new data (store committed before load starts).
//  - addr/wdata assumed stable while mem_stall=1; values sampled only at commit edge.
// CONFIGURATION
//  DMEM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, written on store.
//   - On load commit, parity_err<=mismatch; it is sticky until reset.
//  DMEM_PARITY_EN undefined:
//   - No parity storage; parity_err port still present, tied 0.
// TESTING
//  1 Reset: pc_reset_n=0 mid-WAIT -> next cycle mem_stall=0, rdata=0, rdata_valid=0, store not committed.
//  2 WAIT_STATES=1: store 0xBEEF @0x0005, then load @0x0005 -> mem_stall high 1 cycle each; rdata=0xBEEF with rdata_valid in DONE.
//  3 WAIT_STATES=3: load @0x0010 -> mem_stall high exactly 3 cycles, rdata_valid pulse in 4th cycle, then IDLE.
//  4 Flush: drop mem_write in 2nd WAIT cycle (WAIT_STATES=3) -> IDLE, mem[addr] unchanged on later load.
//  5 DEPTH=256: store 0x1234 @0x0103, load @0x0003 -> rdata=0x1234. Both read+write high -> treated as store, no rdata_valid.
//  6 DMEM_PARITY_EN: force-flip a stored bit via hierarchy, load -> parity_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, WAIT_STATES stall cycles.
// Optional even-parity protection per word when DMEM_PARITY_EN is defined.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_pc_reset_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_mem_stall,
  output logic        o_parity_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next, w_cnt_cur;
  logic          w_req, w_is_store, w_is_load, w_commit;
  logic [AW-1:0] w_addr;
  logic [15:0]   r_rdata;
  logic          r_rdata_valid;

  logic [15:0]   r_mem [DEPTH];

  assign w_req      = i_mem_read | i_mem_write;
  assign w_is_store = i_mem_write;
  assign w_is_load  = i_mem_read & ~i_mem_write;
  assign w_addr     = i_addr[AW-1:0];

  generate
    if (AW < 16) begin : g_addr_alias
      logic w_unused_addr;
      assign w_unused_addr = ^i_addr[15:AW];
    end
  endgenerate

  // The accepting IDLE cycle is the first stall cycle, so it counts as cnt=WAIT_STATES-1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cnt_cur    = r_cnt;
    o_mem_stall  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (r_state == S_IDLE) w_cnt_cur = WS_M1;
        o_mem_stall = w_req;
        if (!w_req) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else if (w_cnt_cur == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = S_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_state_next = S_WAIT;
          w_cnt_next   = w_cnt_cur - 4'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_pc_reset_n) begin
    if (!i_pc_reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_rdata       <= 16'd0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_rdata_valid <= w_commit & w_is_load;
      if (w_commit && w_is_load) r_rdata <= r_mem[w_addr];
    end
  end

  // Storage is never reset so that an aborted access leaves contents intact.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_is_store) r_mem[w_addr] <= i_wdata;
  end

  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;

`ifdef DMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;

  always_ff @(posedge i_clk) begin
    if (w_commit && w_is_store) r_par[w_addr] <= ^i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_pc_reset_n) begin
    if (!i_pc_reset_n) begin
      r_parity_err <= 1'b0;
    end else if (w_commit && w_is_load) begin
      r_parity_err <= r_parity_err | ((^r_mem[w_addr]) ^ r_par[w_addr]);
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder: one instance with WAIT_STATES=1, one with 3.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        valid [2];
  logic        stall [2];
  logic        perr  [2];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_dut0 (
    .i_clk(clk), .i_pc_reset_n(rst_n),
    .i_mem_read(rd[0]), .i_mem_write(wr[0]), .i_addr(addr[0]), .i_wdata(wdata[0]),
    .o_rdata(rdata[0]), .o_rdata_valid(valid[0]), .o_mem_stall(stall[0]), .o_parity_err(perr[0])
  );

  dmem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .i_clk(clk), .i_pc_reset_n(rst_n),
    .i_mem_read(rd[1]), .i_mem_write(wr[1]), .i_addr(addr[1]), .i_wdata(wdata[1]),
    .o_rdata(rdata[1]), .o_rdata_valid(valid[1]), .o_mem_stall(stall[1]), .o_parity_err(perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_stall;
    logic        exp_valid;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a request at the next negedge, counts stall cycles, returns in the DONE cycle with request dropped.
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d, output int n);
    @(negedge clk);
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d;
    #1;
    n = 0;
    while (stall[sel] && n < 40) begin
      n++;
      @(negedge clk);
    end
    rd[sel] = 1'b0; wr[sel] = 1'b0;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 16'h0; wdata[i] = 16'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_stall%0d", i), {31'd0, stall[i]}, 32'd0);
      check($sformatf("reset_valid%0d", i), {31'd0, valid[i]}, 32'd0);
      check($sformatf("reset_rdata%0d", i), {16'd0, rdata[i]}, 32'd0);
      check($sformatf("reset_perr%0d", i), {31'd0, perr[i]}, 32'd0);
    end

    vecs[0]  = '{0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 1, 1'b0, 16'h0000};
    vecs[1]  = '{0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1, 1'b1, 16'hBEEF};
    vecs[2]  = '{0, 1'b0, 1'b1, 16'h0103, 16'h1234, 1, 1'b0, 16'hBEEF};
    vecs[3]  = '{0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1, 1'b1, 16'h1234};
    vecs[4]  = '{0, 1'b1, 1'b1, 16'h0007, 16'hA5A5, 1, 1'b0, 16'h1234};
    vecs[5]  = '{0, 1'b1, 1'b0, 16'h0007, 16'h0000, 1, 1'b1, 16'hA5A5};
    vecs[6]  = '{0, 1'b1, 1'b0, 16'h0305, 16'h0000, 1, 1'b1, 16'hBEEF};
    vecs[7]  = '{1, 1'b0, 1'b1, 16'h0010, 16'hCAFE, 3, 1'b0, 16'h0000};
    vecs[8]  = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 3, 1'b1, 16'hCAFE};
    vecs[9]  = '{1, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 3, 1'b0, 16'hCAFE};
    vecs[10] = '{1, 1'b1, 1'b0, 16'h0120, 16'h0000, 3, 1'b1, 16'h5A5A};
    vecs[11] = '{1, 1'b0, 1'b1, 16'h0030, 16'h1111, 3, 1'b0, 16'h5A5A};
    vecs[12] = '{1, 1'b1, 1'b0, 16'h0030, 16'h0000, 3, 1'b1, 16'h1111};

    for (int i = 0; i < 13; i++) begin
      access(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, n);
      check($sformatf("v%0d_stall_cycles", i), n, vecs[i].exp_stall);
      check($sformatf("v%0d_valid", i), {31'd0, valid[vecs[i].sel]}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_rdata", i), {16'd0, rdata[vecs[i].sel]}, {16'd0, vecs[i].exp_rdata});
    end

    // rdata_valid is a single-cycle pulse; FSM back in IDLE with no stall.
    @(negedge clk);
    check("pulse_end_valid", {31'd0, valid[1]}, 32'd0);
    check("pulse_end_stall", {31'd0, stall[1]}, 32'd0);
    check("pulse_end_rdata_hold", {16'd0, rdata[1]}, 32'h1111);

    // Flush: drop the store in the second WAIT cycle.
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 16'h0030; wdata[1] = 16'h2222;
    #1 check("flush_stall_T", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    check("flush_stall_T1", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    wr[1] = 1'b0;
    #1 check("flush_stall_drop", {31'd0, stall[1]}, 32'd0);
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall[1]}, 32'd0);
    check("flush_idle_valid", {31'd0, valid[1]}, 32'd0);
    access(1, 1'b1, 1'b0, 16'h0030, 16'h0000, n);
    check("flush_load_stall", n, 3);
    check("flush_load_rdata", {16'd0, rdata[1]}, 32'h1111);

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 16'h0030; wdata[1] = 16'h3333;
    @(negedge clk);
    #2;
    rst_n = 1'b0; wr[1] = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, stall[1]}, 32'd0);
    check("rst_mid_valid", {31'd0, valid[1]}, 32'd0);
    check("rst_mid_rdata1", {16'd0, rdata[1]}, 32'd0);
    check("rst_mid_rdata0", {16'd0, rdata[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b1, 1'b0, 16'h0030, 16'h0000, n);
    check("rst_load_stall", n, 3);
    check("rst_load_rdata", {16'd0, rdata[1]}, 32'h1111);
    check("rst_load_valid", {31'd0, valid[1]}, 32'd1);

`ifdef DMEM_PARITY_EN
    access(0, 1'b0, 1'b1, 16'h0042, 16'h00FF, n);
    access(0, 1'b1, 1'b0, 16'h0042, 16'h0000, n);
    check("par_clean", {31'd0, perr[0]}, 32'd0);
    @(negedge clk);
    u_dut0.r_mem[66] = u_dut0.r_mem[66] ^ 16'h0001;
    access(0, 1'b1, 1'b0, 16'h0042, 16'h0000, n);
    check("par_detect", {31'd0, perr[0]}, 32'd1);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, n);
    check("par_sticky", {31'd0, perr[0]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("par_reset", {31'd0, perr[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    check("par_tied0", {31'd0, perr[0]}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
